// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide TX FIFO feeding an 8N1 UART serializer.
// Each serial bit lasts clk_div clock cycles; divisor values below 2 run at 2.
// Optional macro UART_TX_PARITY_EN adds an even parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [DIV_W-1:0]         clk_div,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     ser_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [7:0]       data_reg;
  logic [DIV_W-1:0] period_reg;
  logic [DIV_W-1:0] cycle_cnt;
  logic [2:0]       bit_cnt;
  logic             push;
  logic             pop;
  logic             bit_end;

  assign tx_ready = (fifo_level != LW'(DEPTH));
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (cycle_cnt == period_reg - DIV_W'(1));
  assign busy     = (state != IDLE) || (fifo_level != '0);

  // A byte leaves the FIFO when the serializer is idle, or when a stop bit ends with more data waiting.
  always_comb begin
    pop = 1'b0;
    if (fifo_level != '0) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if ((state == STOP) && bit_end) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because the level counter says what is valid.
  always_ff @(posedge wb_clk_i) begin
    if (push && !wb_rst_i) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Serializer FSM; a pop always starts a new frame, otherwise each state counts out its bit period.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      ser_tx     <= 1'b1;
      data_reg   <= '0;
      period_reg <= '0;
      cycle_cnt  <= '0;
      bit_cnt    <= '0;
    end else if (pop) begin
      data_reg   <= mem[rd_ptr];
      period_reg <= (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
      cycle_cnt  <= '0;
      bit_cnt    <= '0;
      ser_tx     <= 1'b0;
      state      <= START;
    end else begin
      case (state)
        IDLE: begin
          ser_tx    <= 1'b1;
          cycle_cnt <= '0;
        end
        START: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            ser_tx    <= data_reg[0];
            state     <= DATA;
          end else begin
            cycle_cnt <= cycle_cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              ser_tx <= ^data_reg;
              state  <= PARITY;
`else
              ser_tx <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              ser_tx  <= data_reg[bit_cnt + 3'd1];
            end
          end else begin
            cycle_cnt <= cycle_cnt + DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            ser_tx    <= 1'b1;
            state     <= STOP;
          end else begin
            cycle_cnt <= cycle_cnt + DIV_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cycle_cnt <= '0;
            ser_tx    <= 1'b1;
            state     <= IDLE;
          end else begin
            cycle_cnt <= cycle_cnt + DIV_W'(1);
          end
        end
        default: begin
          ser_tx <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo, comparing the serial line against
// frames built from byte queues. Honors UART_TX_PARITY_EN when compiled with it.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [DIV_W-1:0] clk_div;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             ser_tx;
  logic             busy;
  logic [2:0]       fifo_level;

  int checks;
  int failures;
  int cyc;

  logic         obs_ser[$];
  int           obs_lvl[$];
  logic         obs_busy[$];
  logic         obs_ready[$];
  int           acc_cyc[$];
  byte unsigned pend[$];
  byte unsigned stim[$];
  logic         exp_wave[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clk_div   (clk_div),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ser_tx    (ser_tx),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  // Free-running 10-unit clock.
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic int bit_period(input int div);
    return (div < 2) ? 2 : div;
  endfunction

  function automatic int frame_len(input int div);
    return bit_period(div) * NBITS;
  endfunction

  // Append the expected line levels of one whole frame, one entry per clock cycle.
  function automatic void add_frame(input logic [7:0] b, input int div);
    int p;
    p = bit_period(div);
    for (int i = 0; i < p; i++) exp_wave.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < p; i++) exp_wave.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < p; i++) exp_wave.push_back(^b);
`endif
    for (int i = 0; i < p; i++) exp_wave.push_back(1'b1);
  endfunction

  task automatic clear_obs();
    obs_ser.delete();
    obs_lvl.delete();
    obs_busy.delete();
    obs_ready.delete();
    acc_cyc.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    tx_valid = 1'b0;
    wb_rst_i = 1'b1;
    repeat (2) begin
      @(posedge wb_clk_i);
      #1;
    end
    wb_rst_i = 1'b0;
  endtask

  // Offer bytes from pend for n edges, recording DUT outputs after each edge.
  task automatic run_cycles(input int n);
    logic rdy_before;
    for (int i = 0; i < n; i++) begin
      if (pend.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = pend[0];
      end else begin
        tx_valid = 1'b0;
      end
      rdy_before = tx_ready;
      @(posedge wb_clk_i);
      #1;
      if (tx_valid && rdy_before && !wb_rst_i) begin
        acc_cyc.push_back(cyc);
        void'(pend.pop_front());
      end
      obs_ser.push_back(ser_tx);
      obs_lvl.push_back(int'(fifo_level));
      obs_busy.push_back(busy);
      obs_ready.push_back(tx_ready);
      cyc++;
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_obs();
    wb_rst_i = 1'b1;
    pend.delete();
    pend.push_back(8'h5A);
    run_cycles(2);
    checks++;
    if (obs_lvl[1] !== 0 || obs_ready[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_push lvl=%0d ready=%b required lvl=0 ready=1", obs_lvl[1], obs_ready[1]);
    end
    wb_rst_i = 1'b0;
    pend.delete();
    clear_obs();
    run_cycles(20);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs_ser[k] !== 1'b1 || obs_ready[k] !== 1'b1 || obs_busy[k] !== 1'b0 || obs_lvl[k] !== 0) begin
        failures++;
        $display("[TB] FAIL reset_idle cyc=%0d ser=%b ready=%b busy=%b lvl=%0d required 1 1 0 0",
                 k, obs_ser[k], obs_ready[k], obs_busy[k], obs_lvl[k]);
      end
    end
  endtask

  task automatic test_single_frame(input logic [7:0] b, input int div, input string name);
    int a0, total;
    do_reset();
    clk_div = DIV_W'(div);
    exp_wave.delete();
    add_frame(b, div);
    total = exp_wave.size();
    pend.delete();
    pend.push_back(b);
    clear_obs();
    run_cycles(total + 4);
    checks++;
    if (acc_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL %s accepted=%0d required 1", name, acc_cyc.size());
      return;
    end
    a0 = acc_cyc[0];
    checks++;
    if (obs_lvl[a0] !== 1 || obs_ser[a0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s push_edge lvl=%0d ser=%b required 1 1", name, obs_lvl[a0], obs_ser[a0]);
    end
    for (int j = 0; j < total; j++) begin
      checks++;
      if (obs_ser[a0 + 1 + j] !== exp_wave[j] || obs_busy[a0 + 1 + j] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s b=%h cyc=%0d ser=%b busy=%b required ser=%b busy=1",
                 name, b, j, obs_ser[a0 + 1 + j], obs_busy[a0 + 1 + j], exp_wave[j]);
      end
    end
    checks++;
    if (obs_busy[a0 + 1 + total] !== 1'b0 || obs_ser[a0 + 1 + total] !== 1'b1 || obs_lvl[a0 + 1 + total] !== 0) begin
      failures++;
      $display("[TB] FAIL %s end busy=%b ser=%b lvl=%0d required 0 1 0", name,
               obs_busy[a0 + 1 + total], obs_ser[a0 + 1 + total], obs_lvl[a0 + 1 + total]);
    end
  endtask

  task automatic test_back_to_back(input int div, input string name);
    int n, a0, total, peak, exp_peak;
    do_reset();
    clk_div = DIV_W'(div);
    n = stim.size();
    exp_wave.delete();
    foreach (stim[i]) add_frame(stim[i], div);
    total = exp_wave.size();
    pend = stim;
    clear_obs();
    run_cycles(total + 4);
    checks++;
    if (acc_cyc.size() != n) begin
      failures++;
      $display("[TB] FAIL %s accepted=%0d required %0d", name, acc_cyc.size(), n);
      return;
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (acc_cyc[k] !== k) begin
        failures++;
        $display("[TB] FAIL %s accept_cyc byte=%0d got=%0d required %0d", name, k, acc_cyc[k], k);
      end
    end
    a0 = acc_cyc[0];
    for (int j = 0; j < total; j++) begin
      checks++;
      if (obs_ser[a0 + 1 + j] !== exp_wave[j] || obs_busy[a0 + 1 + j] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s cyc=%0d ser=%b busy=%b required ser=%b busy=1",
                 name, j, obs_ser[a0 + 1 + j], obs_busy[a0 + 1 + j], exp_wave[j]);
      end
    end
    checks++;
    if (obs_busy[a0 + 1 + total] !== 1'b0 || obs_ser[a0 + 1 + total] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s end busy=%b ser=%b required 0 1", name,
               obs_busy[a0 + 1 + total], obs_ser[a0 + 1 + total]);
    end
    peak = 0;
    foreach (obs_lvl[i]) if (obs_lvl[i] > peak) peak = obs_lvl[i];
    exp_peak = (n > 1) ? n - 1 : 1;
    checks++;
    if (peak !== exp_peak) begin
      failures++;
      $display("[TB] FAIL %s peak_level got=%0d required %0d", name, peak, exp_peak);
    end
  endtask

  task automatic test_fifo_full();
    int exp_acc[6];
    int exp_pop[6];
    int total, a0, lvl, na, np;
    do_reset();
    clk_div = DIV_W'(8);
    stim.delete();
    exp_wave.delete();
    for (int i = 0; i < 6; i++) begin
      stim.push_back(8'($urandom));
      add_frame(stim[i], 8);
    end
    for (int i = 0; i < 5; i++) exp_acc[i] = i;
    exp_acc[5] = 1 + frame_len(8) + 1;
    for (int m = 0; m < 6; m++) exp_pop[m] = 1 + m * frame_len(8);
    total = exp_wave.size();
    pend = stim;
    clear_obs();
    run_cycles(total + 4);
    checks++;
    if (acc_cyc.size() != 6) begin
      failures++;
      $display("[TB] FAIL full accepted=%0d required 6", acc_cyc.size());
      return;
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (acc_cyc[k] !== exp_acc[k]) begin
        failures++;
        $display("[TB] FAIL full accept_cyc byte=%0d got=%0d required %0d", k, acc_cyc[k], exp_acc[k]);
      end
    end
    for (int k = 0; k < 100; k++) begin
      na = 0;
      np = 0;
      for (int i = 0; i < 6; i++) begin
        if (exp_acc[i] <= k) na++;
        if (exp_pop[i] <= k) np++;
      end
      lvl = na - np;
      checks++;
      if (obs_lvl[k] !== lvl || obs_ready[k] !== (lvl != DEPTH)) begin
        failures++;
        $display("[TB] FAIL full level cyc=%0d lvl=%0d ready=%b required lvl=%0d ready=%b",
                 k, obs_lvl[k], obs_ready[k], lvl, (lvl != DEPTH));
      end
    end
    a0 = acc_cyc[0];
    for (int j = 0; j < total; j++) begin
      checks++;
      if (obs_ser[a0 + 1 + j] !== exp_wave[j]) begin
        failures++;
        $display("[TB] FAIL full_stream cyc=%0d ser=%b required %b", j, obs_ser[a0 + 1 + j], exp_wave[j]);
      end
    end
  endtask

  task automatic test_clk_div();
    int a0, total;
    logic [7:0] b0, b1;
    test_single_frame(8'($urandom), 1, "div1");
    do_reset();
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    exp_wave.delete();
    add_frame(b0, 4);
    add_frame(b1, 10);
    total = exp_wave.size();
    clk_div = DIV_W'(4);
    pend.delete();
    pend.push_back(b0);
    pend.push_back(b1);
    clear_obs();
    run_cycles(10);
    clk_div = DIV_W'(10);
    run_cycles(total - 6);
    checks++;
    if (acc_cyc.size() != 2) begin
      failures++;
      $display("[TB] FAIL div_change accepted=%0d required 2", acc_cyc.size());
      return;
    end
    a0 = acc_cyc[0];
    for (int j = 0; j < total; j++) begin
      checks++;
      if (obs_ser[a0 + 1 + j] !== exp_wave[j]) begin
        failures++;
        $display("[TB] FAIL div_change cyc=%0d ser=%b required %b", j, obs_ser[a0 + 1 + j], exp_wave[j]);
      end
    end
    checks++;
    if (obs_busy[a0 + 1 + total] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL div_change end busy=%b required 0", obs_busy[a0 + 1 + total]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int last;
    do_reset();
    clk_div = DIV_W'(4);
    pend.delete();
    pend.push_back(8'($urandom) & 8'hF7);
    pend.push_back(8'($urandom));
    pend.push_back(8'($urandom));
    clear_obs();
    run_cycles(19);
    checks++;
    if (obs_ser[18] !== 1'b0 || obs_lvl[18] !== 2) begin
      failures++;
      $display("[TB] FAIL rst_mid pre ser=%b lvl=%0d required ser=0 lvl=2", obs_ser[18], obs_lvl[18]);
    end
    wb_rst_i = 1'b1;
    run_cycles(1);
    wb_rst_i = 1'b0;
    last = cyc - 1;
    checks++;
    if (obs_ser[last] !== 1'b1 || obs_lvl[last] !== 0 || obs_busy[last] !== 1'b0 || obs_ready[last] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid post ser=%b lvl=%0d busy=%b ready=%b required 1 0 0 1",
               obs_ser[last], obs_lvl[last], obs_busy[last], obs_ready[last]);
    end
    run_cycles(60);
    for (int k = last + 1; k < cyc; k++) begin
      checks++;
      if (obs_ser[k] !== 1'b1 || obs_busy[k] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_mid after cyc=%0d ser=%b busy=%b required 1 0", k, obs_ser[k], obs_busy[k]);
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    int n;
    checks   = 0;
    failures = 0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    clk_div  = DIV_W'(4);
    wb_rst_i = 1'b1;
    test_reset();
    test_single_frame(8'hA5, 4, "a5");
    repeat (3) test_single_frame(8'($urandom), int'($urandom_range(6, 2)), "rand_frame");
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'hFF);
    stim.push_back(8'h3C);
    test_back_to_back(4, "b2b_fixed");
    repeat (2) begin
      stim.delete();
      n = int'($urandom_range(5, 1));
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      test_back_to_back(int'($urandom_range(5, 2)), "b2b_rand");
    end
    test_fifo_full();
    test_clk_div();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
